// File: rtl/uart_host_client.sv
// uart_host_client
//
// Host-side requester for a buffered UART's FIFO ports.
//   * RX path: pulls 11-bit words {overflow, parity, break, data[7:0]} out of
//     the UART read FIFO, keeps saturating per-flag error counters and offers
//     the byte plus flags on a valid/ready stream. Words carrying a parity or
//     overflow error are swallowed when DROP_BAD is set.
//   * TX path: accepts bytes from a valid/ready stream and pushes them into
//     the UART write FIFO.
// Both FIFO ports use a registered request that stays high until the
// single-cycle acknowledge is sampled. The RX and TX paths are independent.
//
// Ports
//   clk, rst                   clock, asynchronous active-low reset
//   uartEmpty                  read FIFO empty
//   uartReadReq/uartReadAck    read request / one-cycle acknowledge
//   uartDataOut[10:0]          word from read FIFO, valid with uartReadAck
//   uartFull                   write FIFO full
//   uartWriteReq/uartWriteAck  write request / one-cycle acknowledge
//   uartDataIn[10:0]           word to write FIFO ({3'b000, byte})
//   rxValid/rxReady            receive stream handshake
//   rxByte[7:0], rxFlags[2:0]  received byte and {overflow, parity, break}
//   txValid/txReady/txByte     transmit stream
//   clearCounters              synchronous clear of all error counters
//   parityErrors, overflows,
//   breaks                     saturating error counters
module uart_host_client #(
    parameter int ERR_COUNT_WIDTH = 16,
    parameter bit DROP_BAD        = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       uartEmpty,
    output logic                       uartReadReq,
    input  logic                       uartReadAck,
    input  logic [10:0]                uartDataOut,
    input  logic                       uartFull,
    output logic                       uartWriteReq,
    input  logic                       uartWriteAck,
    output logic [10:0]                uartDataIn,
    output logic                       rxValid,
    input  logic                       rxReady,
    output logic [7:0]                 rxByte,
    output logic [2:0]                 rxFlags,
    input  logic                       txValid,
    output logic                       txReady,
    input  logic [7:0]                 txByte,
    input  logic                       clearCounters,
    output logic [ERR_COUNT_WIDTH-1:0] parityErrors,
    output logic [ERR_COUNT_WIDTH-1:0] overflows,
    output logic [ERR_COUNT_WIDTH-1:0] breaks
);

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_HOLD} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_PEND, T_REQ} tx_state_t;

    rx_state_t  rx_state_reg;
    logic       rd_req_reg;
    logic       rx_valid_reg;
    logic [7:0] rx_byte_reg;
    logic [2:0] rx_flags_reg;

    tx_state_t  tx_state_reg;
    logic       wr_req_reg;
    logic       tx_ready_reg;
    logic [7:0] tx_byte_reg;

    // An acknowledge only counts while our request is outstanding; a stray
    // ack in any other state is ignored.
    logic rd_ack_taken;
    logic word_bad;

    assign rd_ack_taken = (rx_state_reg == R_REQ) && uartReadAck;
    assign word_bad     = uartDataOut[10] | uartDataOut[9];

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_reg <= R_IDLE;
            rd_req_reg   <= 1'b0;
            rx_valid_reg <= 1'b0;
            rx_byte_reg  <= 8'h00;
            rx_flags_reg <= 3'b000;
        end else begin
            case (rx_state_reg)
                R_IDLE: begin
                    if (!uartEmpty) begin
                        rd_req_reg   <= 1'b1;
                        rx_state_reg <= R_REQ;
                    end
                end
                R_REQ: begin
                    if (uartReadAck) begin
                        rd_req_reg <= 1'b0;
                        if (word_bad && DROP_BAD) begin
                            rx_state_reg <= R_IDLE;
                        end else begin
                            rx_valid_reg <= 1'b1;
                            rx_byte_reg  <= uartDataOut[7:0];
                            rx_flags_reg <= uartDataOut[10:8];
                            rx_state_reg <= R_HOLD;
                        end
                    end
                end
                R_HOLD: begin
                    if (rxReady) begin
                        rx_valid_reg <= 1'b0;
                        rx_state_reg <= R_IDLE;
                    end
                end
                default: begin
                    rd_req_reg   <= 1'b0;
                    rx_valid_reg <= 1'b0;
                    rx_state_reg <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Error counters: index 0 = break (bit 8), 1 = parity (bit 9),
    // 2 = overflow (bit 10). Clear has priority over an increment.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [ERR_COUNT_WIDTH-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (clearCounters) begin
                    cnt_reg <= '0;
                end else if (rd_ack_taken && uartDataOut[8+gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + ERR_COUNT_WIDTH'(1);
                end
            end
        end
    endgenerate

    assign breaks       = g_cnt[0].cnt_reg;
    assign parityErrors = g_cnt[1].cnt_reg;
    assign overflows    = g_cnt[2].cnt_reg;

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_reg <= T_IDLE;
            wr_req_reg   <= 1'b0;
            tx_ready_reg <= 1'b1;
            tx_byte_reg  <= 8'h00;
        end else begin
            case (tx_state_reg)
                T_IDLE: begin
                    if (txValid) begin
                        tx_byte_reg  <= txByte;
                        tx_ready_reg <= 1'b0;
                        tx_state_reg <= T_PEND;
                    end
                end
                T_PEND: begin
                    if (!uartFull) begin
                        wr_req_reg   <= 1'b1;
                        tx_state_reg <= T_REQ;
                    end
                end
                T_REQ: begin
                    // uartFull is deliberately not looked at here: once the
                    // request is up it stays up until the ack.
                    if (uartWriteAck) begin
                        wr_req_reg   <= 1'b0;
                        tx_ready_reg <= 1'b1;
                        tx_state_reg <= T_IDLE;
                    end
                end
                default: begin
                    wr_req_reg   <= 1'b0;
                    tx_ready_reg <= 1'b1;
                    tx_state_reg <= T_IDLE;
                end
            endcase
        end
    end

    assign uartReadReq  = rd_req_reg;
    assign rxValid      = rx_valid_reg;
    assign rxByte       = rx_byte_reg;
    assign rxFlags      = rx_flags_reg;
    assign uartWriteReq = wr_req_reg;
    assign txReady      = tx_ready_reg;
    assign uartDataIn   = {3'b000, tx_byte_reg};

endmodule

// File: tb/tb_uart_host_client.sv
// tb_uart_host_client
//
// Randomized bench for uart_host_client. The UART FIFOs are modelled as
// queues; the reference model is a list of words expected on the RX stream,
// a list of bytes expected at the write FIFO, and three saturating flag
// counts, all derived from the words and bytes handed to the design.
module tb_uart_host_client;

    localparam int CW      = 3;
    localparam bit DROP    = 1'b1;
    localparam int SAT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          uartEmpty;
    logic          uartReadReq;
    logic          uartReadAck;
    logic [10:0]   uartDataOut;
    logic          uartFull;
    logic          uartWriteReq;
    logic          uartWriteAck;
    logic [10:0]   uartDataIn;
    logic          rxValid;
    logic          rxReady;
    logic [7:0]    rxByte;
    logic [2:0]    rxFlags;
    logic          txValid;
    logic          txReady;
    logic [7:0]    txByte;
    logic          clearCounters;
    logic [CW-1:0] parityErrors;
    logic [CW-1:0] overflows;
    logic [CW-1:0] breaks;

    uart_host_client #(
        .ERR_COUNT_WIDTH(CW),
        .DROP_BAD       (DROP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uartEmpty    (uartEmpty),
        .uartReadReq  (uartReadReq),
        .uartReadAck  (uartReadAck),
        .uartDataOut  (uartDataOut),
        .uartFull     (uartFull),
        .uartWriteReq (uartWriteReq),
        .uartWriteAck (uartWriteAck),
        .uartDataIn   (uartDataIn),
        .rxValid      (rxValid),
        .rxReady      (rxReady),
        .rxByte       (rxByte),
        .rxFlags      (rxFlags),
        .txValid      (txValid),
        .txReady      (txReady),
        .txByte       (txByte),
        .clearCounters(clearCounters),
        .parityErrors (parityErrors),
        .overflows    (overflows),
        .breaks       (breaks)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state
    logic [10:0] rdq[$];      // contents of the UART read FIFO
    logic [10:0] exp_rx[$];   // {flags, byte} expected on the RX stream
    logic [7:0]  exp_tx[$];   // bytes expected at the write FIFO
    logic [7:0]  tx_src[$];   // directed bytes to send
    int          m_cnt[3];    // break, parity, overflow
    bit          rd_ack_last = 1'b0;
    bit          wr_ack_last = 1'b0;
    bit          wr_req_last = 1'b0;
    bit          rx_stall    = 1'b0;
    logic [10:0] rx_last     = '0;
    bit          hold_rx     = 1'b0;
    bit          hold_wr     = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_brk"}, 32'(breaks),       32'(m_cnt[0]));
        check({tag, "_par"}, 32'(parityErrors), 32'(m_cnt[1]));
        check({tag, "_ovf"}, 32'(overflows),    32'(m_cnt[2]));
    endtask

    function automatic logic [10:0] gen_word();
        logic [2:0] f;
        logic [7:0] d;
        d = 8'($urandom);
        f = ($urandom_range(0, 7) < 4) ? 3'b000 : 3'($urandom);
        return {f, d};
    endfunction

    // One clock cycle: observe the post-edge state, then drive the inputs
    // for the next edge and advance the model to what that edge must do.
    task automatic step(input bit rnd);
        logic [10:0] w;
        logic [10:0] e;
        logic [7:0]  eb;
        bit          clr;
        @(posedge clk);
        #1;
        cyc++;
        if (rd_ack_last) check("rd_req_drop", 32'(uartReadReq), 32'd0);
        if (wr_ack_last) begin
            check("wr_req_drop", 32'(uartWriteReq), 32'd0);
            check("tx_ready_ret", 32'(txReady), 32'd1);
        end
        if (uartWriteReq && !wr_req_last) check("wr_req_while_full", 32'(uartFull), 32'd0);
        if (rxValid) check("rd_req_in_hold", 32'(uartReadReq), 32'd0);
        if (rx_stall) check("rx_hold", 32'({rxValid, rxFlags, rxByte}), 32'({1'b1, rx_last}));
        if (cyc % 16 == 0) check_counters("cnt");
        wr_req_last = uartWriteReq;

        clr = rnd && ($urandom_range(0, 199) == 0);
        clearCounters = clr;
        if (clr) for (int i = 0; i < 3; i++) m_cnt[i] = 0;

        // UART read FIFO responder
        rd_ack_last = 1'b0;
        uartReadAck = 1'b0;
        uartDataOut = 11'($urandom);
        if (uartReadReq) begin
            if (!rnd || $urandom_range(0, 2) != 0) begin
                check("rd_req_nonempty", 32'(rdq.size() != 0), 32'd1);
                if (rdq.size() != 0) begin
                    w = rdq.pop_front();
                    uartDataOut = w;
                    uartReadAck = 1'b1;
                    rd_ack_last = 1'b1;
                    if (!clr)
                        for (int i = 0; i < 3; i++)
                            if (w[8+i] && m_cnt[i] < SAT_MAX) m_cnt[i]++;
                    if (!(DROP && (w[10] || w[9]))) exp_rx.push_back(w);
                end
            end
        end else if (rnd && $urandom_range(0, 15) == 0) begin
            uartReadAck = 1'b1;   // stray ack, must be ignored
        end
        if (rnd && rdq.size() < 8 && $urandom_range(0, 3) == 0) rdq.push_back(gen_word());
        uartEmpty = (rdq.size() == 0);

        // RX stream sink
        rx_stall = 1'b0;
        if (hold_rx) rxReady = 1'b0;
        else rxReady = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (rxValid) begin
            if (rxReady) begin
                if (exp_rx.size() == 0) begin
                    check("rx_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_rx.pop_front();
                    check("rx_word", 32'({rxFlags, rxByte}), 32'(e));
                    $display("rx byte=0x%02h flags=%03b (exp 0x%02h %03b)", rxByte, rxFlags, e[7:0], e[10:8]);
                end
            end else begin
                rx_stall = 1'b1;
                rx_last  = {rxFlags, rxByte};
            end
        end

        // TX stream source
        txValid = 1'b0;
        txByte  = 8'($urandom);
        if (rnd ? ($urandom_range(0, 2) == 0) : (tx_src.size() != 0)) begin
            txValid = 1'b1;
            if (!rnd) txByte = tx_src[0];
            if (txReady) begin
                if (!rnd) void'(tx_src.pop_front());
                exp_tx.push_back(txByte);
            end
        end

        // UART write FIFO responder
        wr_ack_last  = 1'b0;
        uartWriteAck = 1'b0;
        if (uartWriteReq) begin
            if (!hold_wr && (!rnd || $urandom_range(0, 2) != 0)) begin
                uartWriteAck = 1'b1;
                wr_ack_last  = 1'b1;
                if (exp_tx.size() == 0) begin
                    check("tx_unexpected", 32'd1, 32'd0);
                end else begin
                    eb = exp_tx.pop_front();
                    check("tx_word", 32'(uartDataIn), 32'({3'b000, eb}));
                    $display("tx word=0x%03h (exp 0x%03h)", uartDataIn, {3'b000, eb});
                end
            end
        end else if (rnd && $urandom_range(0, 15) == 0) begin
            uartWriteAck = 1'b1;  // stray ack, must be ignored
        end
        uartFull = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
    endtask

    initial begin
        int k;
        rst           = 1'b0;
        uartEmpty     = 1'b1;
        uartReadAck   = 1'b0;
        uartDataOut   = '0;
        uartFull      = 1'b0;
        uartWriteAck  = 1'b0;
        rxReady       = 1'b0;
        txValid       = 1'b0;
        txByte        = '0;
        clearCounters = 1'b0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_req",  32'(uartReadReq),  32'd0);
        check("rst_wr_req",  32'(uartWriteReq), 32'd0);
        check("rst_rx_valid", 32'(rxValid),     32'd0);
        check("rst_tx_ready", 32'(txReady),     32'd1);
        check("rst_rx_byte", 32'({rxFlags, rxByte}), 32'd0);
        check("rst_data_in", 32'(uartDataIn),   32'd0);
        check_counters("rst_cnt");
        $display("reset released");
        @(negedge clk) rst = 1'b1;

        // Random traffic, then drain with everything ready.
        repeat (3000) step(1'b1);
        for (int i = 0; i < 300; i++) step(1'b0);
        check("drain_rdq",    32'(rdq.size()),    32'd0);
        check("drain_exp_rx", 32'(exp_rx.size()), 32'd0);
        check("drain_exp_tx", 32'(exp_tx.size()), 32'd0);
        check_counters("drain_cnt");

        // Park the RX side in R_HOLD and the TX side in T_REQ, then reset.
        hold_rx = 1'b1;
        hold_wr = 1'b1;
        rdq.push_back(11'h033);
        tx_src.push_back(8'h33);
        k = 0;
        while (!(rxValid && uartWriteReq) && k < 30) begin
            step(1'b0);
            k++;
        end
        check("reach_hold", 32'(rxValid && uartWriteReq), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_rd_req",   32'(uartReadReq),  32'd0);
        check("mid_rst_wr_req",   32'(uartWriteReq), 32'd0);
        check("mid_rst_rx_valid", 32'(rxValid),      32'd0);
        check("mid_rst_tx_ready", 32'(txReady),      32'd1);
        $display("reset applied mid-transfer");
        exp_rx.delete();
        exp_tx.delete();
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        check_counters("mid_rst_cnt");
        rd_ack_last   = 1'b0;
        wr_ack_last   = 1'b0;
        wr_req_last   = 1'b0;
        rx_stall      = 1'b0;
        hold_rx       = 1'b0;
        hold_wr       = 1'b0;
        uartReadAck   = 1'b0;
        uartWriteAck  = 1'b0;
        txValid       = 1'b0;
        clearCounters = 1'b0;
        uartEmpty     = (rdq.size() == 0);
        @(negedge clk) rst = 1'b1;

        // Normal 0x33 transfer in both directions after reset.
        rdq.push_back(11'h033);
        tx_src.push_back(8'h33);
        uartEmpty = 1'b0;
        for (int i = 0; i < 40; i++) step(1'b0);
        check("post_rst_rdq",    32'(rdq.size()),    32'd0);
        check("post_rst_exp_rx", 32'(exp_rx.size()), 32'd0);
        check("post_rst_tx_src", 32'(tx_src.size()), 32'd0);
        check("post_rst_exp_tx", 32'(exp_tx.size()), 32'd0);
        check_counters("post_rst_cnt");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
